// File: rtl/soc_system_pio_pkg.sv
// Shared register map and channel-state type for the pulse-capable output PIO.
package soc_system_pio_pkg;

    localparam logic [2:0] ADDR_DATA      = 3'd0;
    localparam logic [2:0] ADDR_SET       = 3'd1;
    localparam logic [2:0] ADDR_CLEAR     = 3'd2;
    localparam logic [2:0] ADDR_PULSE     = 3'd3;
    localparam logic [2:0] ADDR_PULSE_LEN = 3'd4;
    localparam logic [2:0] ADDR_DONE      = 3'd5;
    localparam logic [2:0] ADDR_IRQ_MASK  = 3'd6;

    typedef enum logic {
        IDLE,
        PULSING
    } chan_state_t;

endpackage

// File: rtl/soc_system_pio_pulse_chan.sv
// One output bit: direct load/cancel or a self-timed pulse of programmable length.
module soc_system_pio_pulse_chan
    import soc_system_pio_pkg::*;
#(
    parameter int   COUNT_W   = 16,
    parameter logic RESET_BIT = 1'b0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               cancel,
    input  logic               force_val,
    input  logic [COUNT_W-1:0] len,
    output logic               bit_out,
    output logic               busy,
    output logic               done_pulse
);

    chan_state_t        state, state_nxt;
    logic               bit_q, bit_nxt;
    logic [COUNT_W-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            bit_q <= RESET_BIT;
        end else begin
            state <= state_nxt;
            bit_q <= bit_nxt;
        end
    end

    // The counter is only meaningful while PULSING, and every entry to PULSING loads it.
    always_ff @(posedge clk) begin
        cnt <= cnt_nxt;
    end

    always_comb begin
        state_nxt  = state;
        bit_nxt    = bit_q;
        cnt_nxt    = cnt;
        done_pulse = 1'b0;
        if (start) begin
            state_nxt = PULSING;
            bit_nxt   = 1'b1;
            cnt_nxt   = len;
        end else if (cancel) begin
            state_nxt = IDLE;
            bit_nxt   = force_val;
        end else if (state == PULSING) begin
            if (cnt == COUNT_W'(1)) begin
                state_nxt  = IDLE;
                bit_nxt    = 1'b0;
                done_pulse = 1'b1;
            end else begin
                cnt_nxt = cnt - 1'b1;
            end
        end
    end

    assign bit_out = bit_q;
    assign busy    = (state == PULSING);

endmodule

// File: rtl/soc_system_pio_pulse.sv
// Avalon-MM output PIO with set/clear, self-timed pulses, sticky done flags and a maskable irq.
module soc_system_pio_pulse
    import soc_system_pio_pkg::*;
#(
    parameter int          WIDTH         = 8,
    parameter int          COUNT_W       = 16,
    parameter int          PULSE_DEFAULT = 1,
    parameter logic [31:0] RESET_VALUE   = 32'h0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port,
    output logic             irq
);

    logic               wr_en;
    logic [WIDTH-1:0]   start, cancel, force_val, w1c;
    logic [WIDTH-1:0]   busy, done_pulse, out_bits;
    logic [WIDTH-1:0]   done, irq_mask;
    logic [COUNT_W-1:0] pulse_len, eff_len;
    logic               unused_wd;

    assign wr_en     = chipselect && !write_n;
    assign eff_len   = (pulse_len == '0) ? COUNT_W'(1) : pulse_len;
    assign unused_wd = ^writedata;

    // A DATA write touches every bit; SET/CLEAR touch only their 1 bits.
    always_comb begin
        start     = '0;
        cancel    = '0;
        force_val = '0;
        w1c       = '0;
        if (wr_en) begin
            case (address)
                ADDR_DATA: begin
                    cancel    = '1;
                    force_val = writedata[WIDTH-1:0];
                end
                ADDR_SET: begin
                    cancel    = writedata[WIDTH-1:0];
                    force_val = '1;
                end
                ADDR_CLEAR: cancel = writedata[WIDTH-1:0];
                ADDR_PULSE: start  = writedata[WIDTH-1:0];
                ADDR_DONE:  w1c    = writedata[WIDTH-1:0];
                default: ;
            endcase
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        soc_system_pio_pulse_chan #(
            .COUNT_W  (COUNT_W),
            .RESET_BIT(RESET_VALUE[i])
        ) u_chan (
            .clk       (clk),
            .reset_n   (reset_n),
            .start     (start[i]),
            .cancel    (cancel[i]),
            .force_val (force_val[i]),
            .len       (eff_len),
            .bit_out   (out_bits[i]),
            .busy      (busy[i]),
            .done_pulse(done_pulse[i])
        );
    end

    // A completing pulse wins over a simultaneous W1C of the same bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pulse_len <= COUNT_W'(PULSE_DEFAULT);
            irq_mask  <= '0;
            done      <= '0;
            irq       <= 1'b0;
        end else begin
            if (wr_en && address == ADDR_PULSE_LEN) pulse_len <= writedata[COUNT_W-1:0];
            if (wr_en && address == ADDR_IRQ_MASK)  irq_mask  <= writedata[WIDTH-1:0];
            done <= (done & ~w1c) | done_pulse;
            irq  <= |(done & irq_mask);
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:      readdata[WIDTH-1:0]   = out_bits;
            ADDR_PULSE:     readdata[WIDTH-1:0]   = busy;
            ADDR_PULSE_LEN: readdata[COUNT_W-1:0] = pulse_len;
            ADDR_DONE:      readdata[WIDTH-1:0]   = done;
            ADDR_IRQ_MASK:  readdata[WIDTH-1:0]   = irq_mask;
            default: ;
        endcase
    end

    assign out_port = out_bits;

endmodule

// File: tb/tb_soc_system_pio_pulse.sv
// Bench for soc_system_pio_pulse: vector table, timed pulse sequences, random run against a timestamp model.
module tb_soc_system_pio_pulse;

    localparam int WIDTH   = 8;
    localparam int COUNT_W = 16;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [2:0]       address = '0;
    logic             chipselect = 1'b0;
    logic             write_n = 1'b1;
    logic [31:0]      writedata = '0;
    logic [31:0]      readdata;
    logic [WIDTH-1:0] out_port;
    logic             irq;

    always #5 clk = ~clk;

    soc_system_pio_pulse #(
        .WIDTH        (WIDTH),
        .COUNT_W      (COUNT_W),
        .PULSE_DEFAULT(1),
        .RESET_VALUE  (32'hA5)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .out_port  (out_port),
        .irq       (irq)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: each busy bit remembers the absolute cycle at which it falls.
    logic [WIDTH-1:0]   m_out, m_done, m_mask;
    logic [COUNT_W-1:0] m_len;
    logic               m_irq;
    int                 m_fall [WIDTH];
    int                 m_n = 0;

    task automatic model_reset();
        m_out  = 8'hA5;
        m_done = '0;
        m_mask = '0;
        m_len  = 16'd1;
        m_irq  = 1'b0;
        for (int i = 0; i < WIDTH; i++) m_fall[i] = -1;
    endtask

    task automatic model_edge(input logic acc, input logic [2:0] a, input logic [31:0] d);
        logic [WIDTH-1:0] set_d;
        logic [WIDTH-1:0] nxt;
        logic             nirq;
        logic             hit, pul;
        int               eff;
        set_d = '0;
        nxt   = m_out;
        eff   = (m_len == 0) ? 1 : int'(m_len);
        m_n++;
        nirq  = |(m_done & m_mask);
        for (int i = 0; i < WIDTH; i++) begin
            hit = acc && (a == 3'd0 || ((a == 3'd1 || a == 3'd2) && d[i]));
            pul = acc && a == 3'd3 && d[i];
            if (pul) begin
                nxt[i]    = 1'b1;
                m_fall[i] = m_n + eff;
            end else if (hit) begin
                nxt[i]    = (a == 3'd0) ? d[i] : (a == 3'd1);
                m_fall[i] = -1;
            end else if (m_fall[i] == m_n) begin
                nxt[i]    = 1'b0;
                m_fall[i] = -1;
                set_d[i]  = 1'b1;
            end
        end
        m_out = nxt;
        if (acc && a == 3'd5) m_done = m_done & ~d[WIDTH-1:0];
        m_done = m_done | set_d;
        if (acc && a == 3'd4) m_len = d[COUNT_W-1:0];
        if (acc && a == 3'd6) m_mask = d[WIDTH-1:0];
        m_irq = nirq;
    endtask

    function automatic logic [31:0] model_read(input logic [2:0] a);
        logic [31:0]      r;
        logic [WIDTH-1:0] b;
        r = '0;
        b = '0;
        for (int i = 0; i < WIDTH; i++) b[i] = (m_fall[i] != -1);
        case (a)
            3'd0:    r = 32'(m_out);
            3'd3:    r = 32'(b);
            3'd4:    r = 32'(m_len);
            3'd5:    r = 32'(m_done);
            3'd6:    r = 32'(m_mask);
            default: r = '0;
        endcase
        return r;
    endfunction

    // Drive one bus cycle from a falling edge, let the rising edge act, return at the next falling edge.
    task automatic step(input logic cs, input logic wn, input logic [2:0] a, input logic [31:0] d);
        chipselect = cs;
        write_n    = wn;
        address    = a;
        writedata  = d;
        @(posedge clk);
        model_edge(cs && !wn, a, d);
        @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        step(1'b1, 1'b0, a, d);
    endtask

    task automatic idle(input logic [2:0] a);
        step(1'b0, 1'b1, a, 32'h0);
    endtask

    typedef struct {
        logic        w;
        logic [2:0]  a;
        logic [31:0] d;
        logic [7:0]  exp_out;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t vecs [15];

    initial begin
        int hi;
        logic        cs, wn;
        logic [2:0]  a;
        logic [31:0] d;

        vecs[0]  = '{1'b0, 3'd0, 32'h0,        8'hA5, 32'h000000A5, 1'b0};
        vecs[1]  = '{1'b0, 3'd4, 32'h0,        8'hA5, 32'h00000001, 1'b0};
        vecs[2]  = '{1'b0, 3'd5, 32'h0,        8'hA5, 32'h00000000, 1'b0};
        vecs[3]  = '{1'b0, 3'd6, 32'h0,        8'hA5, 32'h00000000, 1'b0};
        vecs[4]  = '{1'b1, 3'd0, 32'h0,        8'h00, 32'h00000000, 1'b0};
        vecs[5]  = '{1'b1, 3'd1, 32'h0F,       8'h0F, 32'h00000000, 1'b0};
        vecs[6]  = '{1'b1, 3'd2, 32'h03,       8'h0C, 32'h00000000, 1'b0};
        vecs[7]  = '{1'b0, 3'd0, 32'h0,        8'h0C, 32'h0000000C, 1'b0};
        vecs[8]  = '{1'b1, 3'd4, 32'h00012345, 8'h0C, 32'h00002345, 1'b0};
        vecs[9]  = '{1'b1, 3'd6, 32'hFFFFFF0F, 8'h0C, 32'h0000000F, 1'b0};
        vecs[10] = '{1'b1, 3'd7, 32'hFFFFFFFF, 8'h0C, 32'h00000000, 1'b0};
        vecs[11] = '{1'b1, 3'd0, 32'hFFFFFF3C, 8'h3C, 32'h0000003C, 1'b0};
        vecs[12] = '{1'b1, 3'd4, 32'h5,        8'h3C, 32'h00000005, 1'b0};
        vecs[13] = '{1'b1, 3'd6, 32'h04,       8'h3C, 32'h00000004, 1'b0};
        vecs[14] = '{1'b1, 3'd0, 32'h0,        8'h00, 32'h00000000, 1'b0};

        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            step(vecs[i].w, !vecs[i].w, vecs[i].a, vecs[i].d);
            chk($sformatf("vec%0d_out", i), 32'(out_port), 32'(vecs[i].exp_out));
            chk($sformatf("vec%0d_rd", i), readdata, vecs[i].exp_rd);
            chk($sformatf("vec%0d_irq", i), 32'(irq), 32'(vecs[i].exp_irq));
        end

        // Pulse bit 2 for 5 cycles with its irq enabled.
        wr(3'd3, 32'h04);
        chk("pulse_rise", 32'(out_port), 32'h04);
        chk("pulse_busy", readdata, 32'h04);
        for (int k = 1; k <= 5; k++) begin
            idle(3'd3);
            chk($sformatf("pulse_out_k%0d", k), 32'(out_port), (k < 5) ? 32'h04 : 32'h00);
            chk($sformatf("pulse_busy_k%0d", k), readdata, (k < 5) ? 32'h04 : 32'h00);
        end
        chk("pulse_irq_lag", 32'(irq), 32'h0);
        address = 3'd5;
        #1;
        chk("pulse_done", readdata, 32'h04);
        idle(3'd5);
        chk("pulse_irq_rise", 32'(irq), 32'h1);
        wr(3'd5, 32'h04);
        chk("pulse_w1c", readdata, 32'h0);
        idle(3'd5);
        chk("pulse_irq_fall", 32'(irq), 32'h0);

        // Retrigger bit 0 four cycles into a 10-cycle pulse.
        wr(3'd4, 32'd10);
        wr(3'd3, 32'h01);
        hi = out_port[0] ? 1 : 0;
        for (int k = 1; k <= 20; k++) begin
            if (k == 4) wr(3'd3, 32'h01);
            else idle(3'd5);
            if (out_port[0]) hi++;
            if (k == 10) begin
                chk("retrig_no_early_done", readdata, 32'h0);
                chk("retrig_still_high", 32'(out_port[0]), 32'h1);
            end
            if (k == 14) chk("retrig_fall_edge", 32'(out_port[0]), 32'h0);
        end
        chk("retrig_high_cycles", 32'(hi), 32'd14);
        chk("retrig_done_once", readdata, 32'h01);
        wr(3'd5, 32'h01);

        // Cancel a running pulse with CLEAR.
        wr(3'd3, 32'h01);
        idle(3'd3);
        idle(3'd3);
        chk("cancel_before", 32'(out_port[0]), 32'h1);
        wr(3'd2, 32'h01);
        chk("cancel_fall", 32'(out_port[0]), 32'h0);
        repeat (12) idle(3'd3);
        chk("cancel_not_busy", readdata, 32'h0);
        idle(3'd5);
        chk("cancel_no_done", readdata, 32'h0);
        chk("cancel_out", 32'(out_port), 32'h0);

        // Zero length behaves as one cycle.
        wr(3'd4, 32'h0);
        chk("len0_reads0", readdata, 32'h0);
        wr(3'd3, 32'hFF);
        chk("len0_high", 32'(out_port), 32'hFF);
        idle(3'd5);
        chk("len0_low", 32'(out_port), 32'h00);
        chk("len0_done", readdata, 32'hFF);
        wr(3'd5, 32'hFF);
        chk("len0_w1c", readdata, 32'h0);
        idle(3'd6);
        chk("len0_irq_fall", 32'(irq), 32'h0);

        // Completion and W1C of the same DONE bit on one edge.
        wr(3'd4, 32'd1);
        wr(3'd3, 32'h08);
        wr(3'd5, 32'h08);
        chk("setwins_done", readdata, 32'h08);
        chk("setwins_out", 32'(out_port), 32'h00);
        wr(3'd6, 32'h08);
        idle(3'd0);
        chk("setwins_irq", 32'(irq), 32'h1);

        // Asynchronous reset in the middle of a pulse.
        wr(3'd4, 32'd20);
        wr(3'd3, 32'hF0);
        idle(3'd5);
        chk("areset_pre_out", 32'(out_port), 32'hF0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("areset_out", 32'(out_port), 32'hA5);
        chk("areset_irq", 32'(irq), 32'h0);
        chk("areset_done", readdata, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        idle(3'd4);
        chk("areset_len", readdata, 32'h1);
        idle(3'd6);
        chk("areset_mask", readdata, 32'h0);
        chk("areset_out_hold", 32'(out_port), 32'hA5);

        // Random traffic against the model.
        for (int k = 0; k < 600; k++) begin
            cs = ($urandom_range(0, 3) != 0);
            wn = ($urandom_range(0, 2) == 0);
            a  = 3'($urandom_range(0, 7));
            d  = $urandom;
            if (a == 3'd4) d = $urandom_range(0, 6);
            step(cs, wn, a, d);
            chk($sformatf("rnd%0d_out", k), 32'(out_port), 32'(m_out));
            chk($sformatf("rnd%0d_irq", k), 32'(irq), 32'(m_irq));
            chk($sformatf("rnd%0d_rd", k), readdata, model_read(a));
        end

        chipselect = 1'b0;
        write_n    = 1'b1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
